opex_receiver: RTL and testbench

OPEX_RECEIVER -- requirements
Module: opex_receiver

---
 rtl/p_hardisc.sv | 28 ++
 rtl/operand_fwd_mux.sv | 17 +
 rtl/opex_receiver.sv | 96 +++++++++
 tb/tb_opex_receiver.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/p_hardisc.sv
// Shared pipeline types and constants for the OP/EX boundary: control
// indicator, register-file address, forwarding bit positions and EX-stage FSM.
package p_hardisc;

  typedef logic [6:0] ictrl;
  typedef logic [4:0] rf_add;

  localparam ictrl ICTRL_NONE     = 7'h00;
  localparam ictrl ICTRL_UNIT_ALU = 7'h01;
  localparam ictrl ICTRL_UNIT_BRU = 7'h02;
  localparam ictrl ICTRL_UNIT_LSU = 7'h04;
  localparam ictrl ICTRL_UNIT_MDU = 7'h08;
  localparam ictrl ICTRL_UNIT_CSR = 7'h10;
  localparam ictrl ICTRL_RVC      = 7'h20;
  localparam ictrl ICTRL_REG_DEST = 7'h40;

  localparam int unsigned FWD_MA1 = 0;
  localparam int unsigned FWD_MA2 = 1;
  localparam int unsigned FWD_WB1 = 2;
  localparam int unsigned FWD_WB2 = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } opex_state;

endpackage

// File: rtl/operand_fwd_mux.sv
// 3:1 operand selector; the MA-stage result wins over WB when both are requested.
module operand_fwd_mux (
  input  logic        s_sel_ma_i,
  input  logic        s_sel_wb_i,
  input  logic [31:0] s_reg_i,
  input  logic [31:0] s_ma_i,
  input  logic [31:0] s_wb_i,
  output logic [31:0] s_val_o
);

  always_comb begin
    if (s_sel_ma_i)      s_val_o = s_ma_i;
    else if (s_sel_wb_i) s_val_o = s_wb_i;
    else                 s_val_o = s_reg_i;
  end

endmodule

// File: rtl/opex_receiver.sv
// OP->EX pipeline register with late operand forwarding; a stalled instruction
// captures its resolved operands once so it no longer depends on MA/WB results.
module opex_receiver
  import p_hardisc::*;
(
  input  logic        s_clk_i,
  input  logic        s_rst_i,
  input  logic [31:0] s_operand1_i,
  input  logic [31:0] s_operand2_i,
  input  logic [3:0]  s_fwd_i,
  input  logic        s_bubble_i,
  input  ictrl        s_idop_ictrl_i,
  input  rf_add       s_idop_rd_i,
  input  logic [31:0] s_exma_val_i,
  input  logic [31:0] s_mawb_val_i,
  input  logic        s_stall_i,
  input  logic        s_flush_i,
  output logic [31:0] s_op1_o,
  output logic [31:0] s_op2_o,
  output ictrl        s_opex_ictrl_o,
  output rf_add       s_opex_rd_o,
  output logic [3:0]  s_opex_fwd_o,
  output logic        s_held_o
);

  opex_state   r_state;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [3:0]  r_fwd;
  ictrl        r_ictrl;
  rf_add       r_rd;
  logic [31:0] w_op1;
  logic [31:0] w_op2;

  operand_fwd_mux u_fwd_op1 (
    .s_sel_ma_i (r_fwd[FWD_MA1]),
    .s_sel_wb_i (r_fwd[FWD_WB1]),
    .s_reg_i    (r_op1),
    .s_ma_i     (s_exma_val_i),
    .s_wb_i     (s_mawb_val_i),
    .s_val_o    (w_op1)
  );

  operand_fwd_mux u_fwd_op2 (
    .s_sel_ma_i (r_fwd[FWD_MA2]),
    .s_sel_wb_i (r_fwd[FWD_WB2]),
    .s_reg_i    (r_op2),
    .s_ma_i     (s_exma_val_i),
    .s_wb_i     (s_mawb_val_i),
    .s_val_o    (w_op2)
  );

  always_ff @(posedge s_clk_i or posedge s_rst_i) begin
    if (s_rst_i) begin
      r_state <= EMPTY;
      r_op1   <= '0;
      r_op2   <= '0;
      r_fwd   <= '0;
      r_ictrl <= ICTRL_NONE;
      r_rd    <= '0;
    end else if (s_flush_i) begin
      r_state <= EMPTY;
      r_fwd   <= '0;
      r_ictrl <= ICTRL_NONE;
    end else if (s_stall_i) begin
      // Freeze the forwarded values now; later MA/WB changes must not leak in.
      if (r_state != EMPTY) begin
        r_op1   <= w_op1;
        r_op2   <= w_op2;
        r_fwd   <= '0;
        r_state <= HELD;
      end
    end else begin
      r_op1 <= s_operand1_i;
      r_op2 <= s_operand2_i;
      r_rd  <= s_idop_rd_i;
      if (s_bubble_i || (s_idop_ictrl_i == ICTRL_NONE)) begin
        r_ictrl <= ICTRL_NONE;
        r_fwd   <= '0;
        r_state <= EMPTY;
      end else begin
        r_ictrl <= s_idop_ictrl_i;
        r_fwd   <= s_fwd_i;
        r_state <= FRESH;
      end
    end
  end

  assign s_op1_o        = w_op1;
  assign s_op2_o        = w_op2;
  assign s_opex_ictrl_o = r_ictrl;
  assign s_opex_rd_o    = r_rd;
  assign s_opex_fwd_o   = r_fwd;
  assign s_held_o       = (r_state == HELD);

endmodule

// File: tb/tb_opex_receiver.sv
// Scoreboard bench for opex_receiver: stimulus pushes expected EX contents,
// a monitor pops and compares one entry after every rising edge.
module tb_opex_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] operand1 = '0, operand2 = '0;
  logic [3:0]  fwd = '0;
  logic        bubble = 1'b0;
  logic [6:0]  idop_ictrl = '0;
  logic [4:0]  idop_rd = '0;
  logic [31:0] exma_val = '0, mawb_val = '0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] op1, op2;
  logic [6:0]  opex_ictrl;
  logic [4:0]  opex_rd;
  logic [3:0]  opex_fwd;
  logic        held;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    bit          ops;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [6:0]  ictrl;
    logic [4:0]  rd;
    logic [3:0]  fwd;
    logic        held;
  } exp_t;

  exp_t sb[$];

  opex_receiver dut (
    .s_clk_i        (clk),
    .s_rst_i        (rst),
    .s_operand1_i   (operand1),
    .s_operand2_i   (operand2),
    .s_fwd_i        (fwd),
    .s_bubble_i     (bubble),
    .s_idop_ictrl_i (idop_ictrl),
    .s_idop_rd_i    (idop_rd),
    .s_exma_val_i   (exma_val),
    .s_mawb_val_i   (mawb_val),
    .s_stall_i      (stall),
    .s_flush_i      (flush),
    .s_op1_o        (op1),
    .s_op2_o        (op2),
    .s_opex_ictrl_o (opex_ictrl),
    .s_opex_rd_o    (opex_rd),
    .s_opex_fwd_o   (opex_fwd),
    .s_held_o       (held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input exp_t e);
    if (e.ops) begin
      chk({e.name, ".op1"}, op1, e.op1);
      chk({e.name, ".op2"}, op2, e.op2);
      chk({e.name, ".rd"}, {27'd0, opex_rd}, {27'd0, e.rd});
    end
    chk({e.name, ".ictrl"}, {25'd0, opex_ictrl}, {25'd0, e.ictrl});
    chk({e.name, ".fwd"}, {28'd0, opex_fwd}, {28'd0, e.fwd});
    chk({e.name, ".held"}, {31'd0, held}, {31'd0, e.held});
  endtask

  function automatic exp_t mk(input string nm, input bit ops, input logic [31:0] o1,
                              input logic [31:0] o2, input logic [6:0] ic, input logic [4:0] rd,
                              input logic [3:0] fw, input logic hd);
    exp_t e;
    e.name = nm; e.ops = ops; e.op1 = o1; e.op2 = o2;
    e.ictrl = ic; e.rd = rd; e.fwd = fw; e.held = hd;
    return e;
  endfunction

  // Drive one cycle of inputs after a falling edge and queue what EX must show after the next rising edge.
  task automatic step(input logic st, input logic fl, input logic bb, input logic [3:0] fw,
                      input logic [6:0] ic, input logic [4:0] rd, input logic [31:0] o1,
                      input logic [31:0] o2, input logic [31:0] ex, input logic [31:0] mw,
                      input exp_t e);
    @(negedge clk);
    stall = st; flush = fl; bubble = bb; fwd = fw; idop_ictrl = ic; idop_rd = rd;
    operand1 = o1; operand2 = o2; exma_val = ex; mawb_val = mw;
    sb.push_back(e);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk_all(e);
      end
    end
  end

  initial begin : stim
    #2;
    chk_all(mk("reset", 1'b1, 32'h0, 32'h0, 7'h0, 5'd0, 4'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    // Forward op1 from MA, then stall three cycles while the MA value moves on
    step(0,0,0, 4'b0001, 7'h10, 5'd3, 32'h10, 32'h20, 32'hAAAA_0000, 32'hBBBB,
         mk("load_fwd_ma", 1, 32'hAAAA_0000, 32'h20, 7'h10, 5'd3, 4'b0001, 0));
    step(1,0,0, 4'b0000, 7'h00, 5'd0, 32'h0, 32'h0, 32'hAAAA_0000, 32'hBBBB,
         mk("stall1", 1, 32'hAAAA_0000, 32'h20, 7'h10, 5'd3, 4'b0000, 1));
    step(1,0,0, 4'b0000, 7'h00, 5'd0, 32'h0, 32'h0, 32'h1234, 32'hBBBB,
         mk("stall2", 1, 32'hAAAA_0000, 32'h20, 7'h10, 5'd3, 4'b0000, 1));
    step(1,0,0, 4'b0000, 7'h00, 5'd0, 32'h0, 32'h0, 32'h5678, 32'hBBBB,
         mk("stall3", 1, 32'hAAAA_0000, 32'h20, 7'h10, 5'd3, 4'b0000, 1));
    // MA wins over WB
    step(0,0,0, 4'b0101, 7'h11, 5'd4, 32'h10, 32'h22, 32'h1, 32'h2,
         mk("ma_prio", 1, 32'h1, 32'h22, 7'h11, 5'd4, 4'b0101, 0));
    step(0,0,0, 4'b1000, 7'h12, 5'd5, 32'h30, 32'h40, 32'h3, 32'h4,
         mk("op2_wb", 1, 32'h30, 32'h4, 7'h12, 5'd5, 4'b1000, 0));
    step(0,0,1, 4'b0011, 7'h10, 5'd6, 32'h50, 32'h60, 32'h3, 32'h4,
         mk("bubble", 0, 32'h0, 32'h0, 7'h00, 5'd0, 4'b0000, 0));
    step(1,0,0, 4'b1111, 7'h13, 5'd6, 32'h50, 32'h60, 32'h3, 32'h4,
         mk("empty_stall", 0, 32'h0, 32'h0, 7'h00, 5'd0, 4'b0000, 0));
    step(0,0,0, 4'b0000, 7'h20, 5'd7, 32'h55, 32'h66, 32'h3, 32'h4,
         mk("load_plain", 1, 32'h55, 32'h66, 7'h20, 5'd7, 4'b0000, 0));
    step(1,0,0, 4'b0000, 7'h20, 5'd7, 32'h0, 32'h0, 32'h3, 32'h4,
         mk("held_plain", 1, 32'h55, 32'h66, 7'h20, 5'd7, 4'b0000, 1));
    step(1,1,0, 4'b0000, 7'h20, 5'd7, 32'h0, 32'h0, 32'h3, 32'h4,
         mk("flush_over_stall", 0, 32'h0, 32'h0, 7'h00, 5'd0, 4'b0000, 0));
    step(0,0,0, 4'b0011, 7'h00, 5'd8, 32'h7, 32'h8, 32'h3, 32'h4,
         mk("load_nop", 0, 32'h0, 32'h0, 7'h00, 5'd0, 4'b0000, 0));
    step(0,0,0, 4'b0010, 7'h21, 5'd9, 32'h100, 32'h200, 32'hE, 32'hF,
         mk("op2_ma", 1, 32'h100, 32'hE, 7'h21, 5'd9, 4'b0010, 0));
    step(1,0,0, 4'b0000, 7'h00, 5'd0, 32'h0, 32'h0, 32'hE, 32'hF,
         mk("held_op2", 1, 32'h100, 32'hE, 7'h21, 5'd9, 4'b0000, 1));
    drain();

    // Reset between edges while HELD: outputs clear without a clock edge
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_all(mk("async_rst", 1, 32'h0, 32'h0, 7'h0, 5'd0, 4'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    step(0,0,0, 4'b0100, 7'h33, 5'd10, 32'hABC, 32'hDEF, 32'h66, 32'h77,
         mk("post_rst_load", 1, 32'h77, 32'hDEF, 7'h33, 5'd10, 4'b0100, 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
